// File: rtl/velocidade_pkg.sv
// Shared types and constants for the toy speed controller.
package velocidade_pkg;
  localparam int LVL_W = 2;
  localparam logic [LVL_W-1:0] LVL_MAX = 2'd3;

  typedef enum logic [2:0] {
    PARADO,
    ACELERANDO,
    CRUZEIRO,
    DESACELERANDO,
    EMERGENCIA
  } estado_t;

  // Duty per level in quarters of the PWM period: 0, 1/4, 1/2, full.
  localparam logic [3:0][2:0] DUTY_QUARTOS = {3'd4, 3'd2, 3'd1, 3'd0};

  function automatic int unsigned duty_of(input logic [LVL_W-1:0] lvl, input int bits);
    return int'(DUTY_QUARTOS[lvl]) << (bits - 2);
  endfunction
endpackage

// File: rtl/controle_velocidade_if.sv
// Pins of the speed controller: buttons/sensor in, display/motor out.
interface controle_velocidade_if;
  logic botao_acelera;
  logic botao_freia;
  logic sensor_obstaculo;
  logic chave1;
  logic chave2;
  logic pwm_motor;
  logic parado;

  modport master (output botao_acelera, botao_freia, sensor_obstaculo,
                  input  chave1, chave2, pwm_motor, parado);
  modport slave  (input  botao_acelera, botao_freia, sensor_obstaculo,
                  output chave1, chave2, pwm_motor, parado);
endinterface

// File: rtl/debounce_botao.sv
// Active-low pushbutton: 2-flop sync, stable-count debounce, press pulse.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_n,
  output logic evento
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          pressionado;
  logic          estado;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], botao_n};
  end

  assign pressionado = ~sync[1];

  // Any cycle agreeing with the accepted state restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= 1'b0;
      cnt    <= '0;
      evento <= 1'b0;
    end else begin
      evento <= 1'b0;
      if (pressionado == estado) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        estado <= pressionado;
        cnt    <= '0;
        evento <= pressionado;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/controle_velocidade.sv
// Speed controller: target level from buttons, ramped current level, PWM out.
module controle_velocidade
  import velocidade_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RAMP_CYCLES     = 25000000,
  parameter int PWM_BITS        = 8
) (
  input logic clk,
  input logic rst_n,
  controle_velocidade_if.slave io
);
  localparam int RW = $clog2(RAMP_CYCLES + 1);

  logic [1:0]       botoes_n;
  logic [1:0]       ev;
  logic [1:0]       obs_sync;
  logic             obs_s;
  logic             ev_ok, ev_acel, ev_freia;
  logic [LVL_W-1:0] alvo, atual;
  logic [RW-1:0]    ramp;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS:0]   duty;
  estado_t          estado, estado_nx;

  assign botoes_n = {io.botao_freia, io.botao_acelera};

  for (genvar b = 0; b < 2; b++) begin : g_botao
    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .botao_n(botoes_n[b]),
      .evento (ev[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) obs_sync <= 2'b00;
    else        obs_sync <= {obs_sync[0], io.sensor_obstaculo};
  end

  assign obs_s = obs_sync[1];

  // Presses are dropped while the obstacle holds and on the exit cycle.
  assign ev_ok    = (estado != EMERGENCIA) && !obs_s;
  assign ev_acel  = ev[0] && ev_ok;
  assign ev_freia = ev[1] && ev_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alvo  <= '0;
      atual <= '0;
      ramp  <= '0;
    end else if (obs_s) begin
      alvo  <= '0;
      atual <= '0;
      ramp  <= '0;
    end else begin
      if (ev_freia) begin
        if (alvo != '0) alvo <= alvo - 2'd1;
      end else if (ev_acel && alvo != LVL_MAX) begin
        alvo <= alvo + 2'd1;
      end
      // Ramp keeps counting across a mid-count target change.
      if (atual == alvo) begin
        ramp <= '0;
      end else if (ramp == RW'(RAMP_CYCLES - 1)) begin
        ramp  <= '0;
        atual <= (atual < alvo) ? atual + 2'd1 : atual - 2'd1;
      end else begin
        ramp <= ramp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= PARADO;
    else        estado <= estado_nx;
  end

  always_comb begin
    estado_nx = estado;
    if (obs_s) begin
      estado_nx = EMERGENCIA;
    end else begin
      case (estado)
        EMERGENCIA: estado_nx = PARADO;
        default: begin
          if (atual == '0 && alvo == '0) estado_nx = PARADO;
          else if (atual < alvo)         estado_nx = ACELERANDO;
          else if (atual > alvo)         estado_nx = DESACELERANDO;
          else                           estado_nx = CRUZEIRO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign duty         = (PWM_BITS + 1)'(duty_of(atual, PWM_BITS));
  assign io.pwm_motor = {1'b0, pwm_cnt} < duty;
  assign io.chave1    = atual[1];
  assign io.chave2    = atual[0];
  assign io.parado    = (atual == '0);
endmodule

// File: tb/tb_controle_velocidade.sv
// Scoreboarded bench: level changes are popped against an expected-level queue.
module tb_controle_velocidade;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic [1:0] prev_lvl = 2'd0;
  int   t;

  controle_velocidade_if vif();

  controle_velocidade #(.DEBOUNCE_CYCLES(4), .RAMP_CYCLES(8), .PWM_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, req, $time);
    end
  endtask

  function automatic int lvl();
    return {vif.chave1, vif.chave2};
  endfunction

  function automatic int duty_ref(input int l);
    return (l == 3) ? 256 : l * 64;
  endfunction

  function automatic int sat(input int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  // Monitor: every displayed level change must match the next expected level.
  always @(negedge clk) begin
    if (rst_n && lvl() != int'(prev_lvl)) begin
      if (exp_q.size() == 0) chk("unexpected_level_change", lvl(), int'(prev_lvl));
      else                   chk("level_seq", lvl(), exp_q.pop_front());
      chk("parado_on_change", vif.parado, lvl() == 0);
      prev_lvl = 2'(lvl());
    end
  end

  task automatic press(input bit a, input bit f, input int hold);
    vif.botao_acelera = a ? 1'b0 : 1'b1;
    vif.botao_freia   = f ? 1'b0 : 1'b1;
    repeat (hold) @(negedge clk);
    vif.botao_acelera = 1'b1;
    vif.botao_freia   = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_level(input string nome, input int req, input int budget);
    for (int i = 0; i < budget && lvl() != req; i++) @(negedge clk);
    chk(nome, lvl(), req);
  endtask

  task automatic measure_pwm(input string nome, input int req);
    int h = 0;
    repeat (256) begin
      @(negedge clk);
      h += vif.pwm_motor;
    end
    chk(nome, h, req);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int h;
    int op, nt;
    vif.botao_acelera    = 1'b1;
    vif.botao_freia      = 1'b1;
    vif.sensor_obstaculo = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", lvl(), 0);
    chk("reset_parado", vif.parado, 1);
    chk("reset_pwm", vif.pwm_motor, 0);
    rst_n = 1'b1;

    h = 0;
    repeat (512) begin
      @(negedge clk);
      h += vif.pwm_motor;
    end
    chk("idle_pwm_512", h, 0);
    chk("idle_level", lvl(), 0);

    // Press latency: 2 sync + 4 debounce + 1 target + 8 ramp.
    exp_q.push_back(1);
    lat = 0;
    vif.botao_acelera = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat == 0 && lvl() == 1) lat = i;
    end
    vif.botao_acelera = 1'b1;
    repeat (10) @(negedge clk);
    chk("press_latency", lat, 15);
    chk("lvl1_parado", vif.parado, 0);
    measure_pwm("duty_lvl1", duty_ref(1));

    exp_q.push_back(0);
    press(0, 1, 8);
    wait_level("brake_to_0", 0, 60);

    for (int i = 0; i < 15; i++) begin
      vif.botao_acelera = i[0] ? 1'b1 : 1'b0;
      repeat (2) @(negedge clk);
    end
    vif.botao_acelera = 1'b1;
    repeat (30) @(negedge clk);
    chk("bounce_level", lvl(), 0);
    chk("bounce_parado", vif.parado, 1);

    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    repeat (4) press(1, 0, 8);
    wait_level("accel_to_3", 3, 80);
    repeat (30) @(negedge clk);
    chk("saturate_3", lvl(), 3);
    measure_pwm("duty_lvl3", duty_ref(3));

    exp_q.push_back(2);
    press(0, 1, 8);
    wait_level("brake_to_2", 2, 60);
    measure_pwm("duty_lvl2", duty_ref(2));
    exp_q.push_back(1);
    press(1, 1, 8);
    wait_level("both_brake_wins", 1, 60);
    repeat (30) @(negedge clk);
    chk("both_stays_1", lvl(), 1);

    exp_q.push_back(2); exp_q.push_back(3);
    press(1, 0, 8);
    press(1, 0, 8);
    wait_level("accel_to_3b", 3, 60);

    // Accelerate held across the whole emergency.
    vif.botao_acelera = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_saturated", lvl(), 3);
    exp_q.push_back(0);
    vif.sensor_obstaculo = 1'b1;
    repeat (3) @(negedge clk);
    chk("emerg_level", lvl(), 0);
    chk("emerg_pwm", vif.pwm_motor, 0);
    repeat (7) @(negedge clk);
    vif.sensor_obstaculo = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_after_clear", lvl(), 0);
    vif.botao_acelera = 1'b1;
    repeat (20) @(negedge clk);
    chk("released_after_clear", lvl(), 0);
    exp_q.push_back(1);
    press(1, 0, 8);
    wait_level("fresh_press", 1, 60);

    t = 1;
    for (int k = 0; k < 14; k++) begin
      op = $urandom_range(0, 2);
      nt = (op == 0) ? sat(t + 1) : sat(t - 1);
      if (nt != t) exp_q.push_back(nt);
      press(op != 1, op != 0, $urandom_range(8, 12));
      wait_level("rand_level", nt, 60);
      t = nt;
    end
    measure_pwm("rand_duty", duty_ref(t));

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
